// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-cache main-memory port arbiter.
// A word is carried as four bytes, with byte 0 in bits 7:0.
package mem_arb_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef logic [BYTES_PER_WORD-1:0][7:0] word_bytes_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } req_id_t;

   // Assemble a word from its bytes in cache order (byte 0 first).
   function automatic word_bytes_t make_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
      word_bytes_t w;
      w[0] = b0;
      w[1] = b1;
      w[2] = b2;
      w[3] = b3;
      return w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a sole requester wins, and on a tie the requester
// that was not granted last time wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last_grant,
   output req_id_t    grant,
   output logic       valid
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      valid = |req;
      grant = REQ_IC;
      if (req == 2'b11)
         grant = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
      else if (req[1])
         grant = REQ_DC;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the icache and dcache controllers, with
// round-robin arbitration, registered responses and a watchdog abort.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ic_req,
   input  logic [31:0] ic_addr,
   input  logic        ic_we,
   input  word_bytes_t ic_wdata,
   output word_bytes_t ic_rdata,
   output logic        ic_done,
   input  logic        dc_req,
   input  logic [31:0] dc_addr,
   input  logic        dc_we,
   input  word_bytes_t dc_wdata,
   output word_bytes_t dc_rdata,
   output logic        dc_done,
   output logic        mem_start,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output word_bytes_t mem_data_in,
   input  word_bytes_t mem_data_out,
   input  logic        mem_done,
   output logic        err
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, next_state;
   req_id_t           owner, last_grant, pick_id;
   logic              pick_valid;
   logic              grant_fire, finish, timeout;
   logic [CNT_W-1:0]  cnt;
   word_bytes_t       capture_word;

   rr_pick2 u_pick (
      .req        ({dc_req, ic_req}),
      .last_grant (last_grant),
      .grant      (pick_id),
      .valid      (pick_valid)
   );

   always_comb begin
      next_state   = state;
      grant_fire   = 1'b0;
      finish       = 1'b0;
      timeout      = 1'b0;
      capture_word = mem_data_out;
      unique case (state)
         IDLE: if (pick_valid) begin
            grant_fire = 1'b1;
            next_state = BUSY;
         end
         BUSY: if (mem_done) begin
            finish     = 1'b1;
            next_state = RESP;
         end else if (cnt == TIMEOUT_LAST) begin
            finish       = 1'b1;
            timeout      = 1'b1;
            capture_word = '0;
            next_state   = RESP;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner       <= REQ_IC;
         last_grant  <= REQ_IC;
         cnt         <= '0;
         mem_start   <= 1'b0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_data_in <= '0;
         ic_rdata    <= '0;
         dc_rdata    <= '0;
         ic_done     <= 1'b0;
         dc_done     <= 1'b0;
         err         <= 1'b0;
      end else begin
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         err     <= 1'b0;

         if (grant_fire) begin
            owner      <= pick_id;
            last_grant <= pick_id;
            mem_start  <= 1'b1;
            cnt        <= '0;
            if (pick_id == REQ_DC) begin
               mem_addr    <= dc_addr;
               mem_we      <= dc_we;
               mem_data_in <= dc_wdata;
            end else begin
               mem_addr    <= ic_addr;
               mem_we      <= ic_we;
               mem_data_in <= ic_wdata;
            end
         end

         if (state == BUSY && !finish)
            cnt <= cnt + 1'b1;

         // Completion: a read returns memory data, or zero if the watchdog fired.
         if (finish) begin
            mem_start <= 1'b0;
            err       <= timeout;
            if (owner == REQ_DC) begin
               dc_done <= 1'b1;
               if (!mem_we) dc_rdata <= capture_word;
            end else begin
               ic_done <= 1'b1;
               if (!mem_we) ic_rdata <= capture_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of transactions with hand-computed
// owners and read data, plus sequences for stray strobes, zero wait, timeout and reset.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ic_req, ic_we, dc_req, dc_we;
   logic [31:0] ic_addr, dc_addr;
   word_bytes_t ic_wdata, dc_wdata, ic_rdata, dc_rdata;
   logic        ic_done, dc_done;
   logic        mem_start, mem_we, mem_done, err;
   logic [31:0] mem_addr;
   word_bytes_t mem_data_in, mem_data_out;

   mem_port_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .ic_req       (ic_req),
      .ic_addr      (ic_addr),
      .ic_we        (ic_we),
      .ic_wdata     (ic_wdata),
      .ic_rdata     (ic_rdata),
      .ic_done      (ic_done),
      .dc_req       (dc_req),
      .dc_addr      (dc_addr),
      .dc_we        (dc_we),
      .dc_wdata     (dc_wdata),
      .dc_rdata     (dc_rdata),
      .dc_done      (dc_done),
      .mem_start    (mem_start),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .mem_done     (mem_done),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ic_req, dc_req, ic_we, dc_we;
      logic [31:0] ic_addr, dc_addr;
      word_bytes_t ic_wdata, dc_wdata;
      int          wait_cycles;
      word_bytes_t resp;
      req_id_t     exp_owner;
      word_bytes_t exp_rdata;
   } vec_t;

   vec_t        vecs[8];
   vec_t        v;
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          ok;
   int          busy;
   logic [31:0] e_addr;
   logic        e_we;
   word_bytes_t e_wdata, exp_ic_rd, exp_dc_rd;
   word_bytes_t wa, wb, wc, wd, we_, wp, wf, wg, wh;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic wait_start(output bit started);
      started = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (mem_start) begin
            started = 1'b1;
            break;
         end
      end
      n_checks++;
      if (started) n_pass++;
      else $display("FAIL start_wait: mem_start still 0 after 6 cycles, expected 1");
   endtask

   function automatic vec_t mk_vec(input logic icr, input logic dcr, input logic icw, input logic dcw,
                                   input logic [31:0] ica, input logic [31:0] dca,
                                   input word_bytes_t icd, input word_bytes_t dcd, input int wt,
                                   input word_bytes_t rsp, input req_id_t own, input word_bytes_t erd);
      vec_t r;
      r.ic_req = icr; r.dc_req = dcr; r.ic_we = icw; r.dc_we = dcw;
      r.ic_addr = ica; r.dc_addr = dca; r.ic_wdata = icd; r.dc_wdata = dcd;
      r.wait_cycles = wt; r.resp = rsp; r.exp_owner = own; r.exp_rdata = erd;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation ran past 200000 time units");
      $fatal(1, "global timeout");
   end

   initial begin
      wa  = make_word(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      wb  = make_word(8'hB0, 8'hB1, 8'hB2, 8'hB3);
      wc  = make_word(8'hC0, 8'hC1, 8'hC2, 8'hC3);
      wd  = make_word(8'hD0, 8'hD1, 8'hD2, 8'hD3);
      we_ = make_word(8'hE0, 8'hE1, 8'hE2, 8'hE3);
      wp  = make_word(8'h11, 8'h22, 8'h33, 8'h44);
      wf  = make_word(8'hF0, 8'hF1, 8'hF2, 8'hF3);
      wg  = make_word(8'h90, 8'h91, 8'h92, 8'h93);
      wh  = make_word(8'h80, 8'h81, 8'h82, 8'h83);

      // Tie from reset goes to dc, then strict alternation while both request.
      vecs[0] = mk_vec(1, 1, 0, 0, 32'h100, 32'h200, '0, '0, 1, wa, REQ_DC, wa);
      vecs[1] = mk_vec(1, 1, 0, 0, 32'h100, 32'h200, '0, '0, 0, wb, REQ_IC, wb);
      vecs[2] = mk_vec(1, 1, 0, 0, 32'h100, 32'h200, '0, '0, 2, wc, REQ_DC, wc);
      vecs[3] = mk_vec(1, 1, 0, 0, 32'h100, 32'h200, '0, '0, 1, wd, REQ_IC, wd);
      // Single ic read, memory answers 3 cycles after mem_start.
      vecs[4] = mk_vec(1, 0, 0, 0, 32'h0000_1004, 32'h0, '0, '0, 3, wp, REQ_IC, wp);
      // dc write: memory bus data is ignored, dc_rdata keeps the earlier read.
      vecs[5] = mk_vec(0, 1, 0, 1, 32'h0, 32'h0000_2000, '0, make_word(8'hDE, 8'hAD, 8'hBE, 8'hEF),
                       2, make_word(8'h55, 8'h55, 8'h55, 8'h55), REQ_DC, wc);
      // Tie after a dc grant goes to ic (a write), then the waiting dc read.
      vecs[6] = mk_vec(1, 1, 1, 0, 32'h0000_1008, 32'h0000_2004, make_word(8'h01, 8'h02, 8'h03, 8'h04),
                       '0, 1, make_word(8'h66, 8'h66, 8'h66, 8'h66), REQ_IC, wp);
      vecs[7] = mk_vec(0, 1, 0, 0, 32'h0, 32'h0000_2004, '0, '0, 0, we_, REQ_DC, we_);

      reset = 1'b1;
      ic_req = 0; dc_req = 0; ic_we = 0; dc_we = 0; ic_addr = '0; dc_addr = '0;
      ic_wdata = '0; dc_wdata = '0; mem_done = 0; mem_data_out = '0;
      #1;
      check("rst_mem_start", 32'(mem_start), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_data_in", mem_data_in, 32'h0);
      check("rst_ic_done", 32'(ic_done), 32'h0);
      check("rst_dc_done", 32'(dc_done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_ic_rdata", ic_rdata, 32'h0);
      check("rst_dc_rdata", dc_rdata, 32'h0);
      exp_ic_rd = '0;
      exp_dc_rd = '0;
      @(negedge clk);
      @(negedge clk);
      ic_req = 1; dc_req = 1;
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         ic_req = v.ic_req; dc_req = v.dc_req; ic_we = v.ic_we; dc_we = v.dc_we;
         ic_addr = v.ic_addr; dc_addr = v.dc_addr; ic_wdata = v.ic_wdata; dc_wdata = v.dc_wdata;
         e_addr  = (v.exp_owner == REQ_DC) ? v.dc_addr : v.ic_addr;
         e_we    = (v.exp_owner == REQ_DC) ? v.dc_we : v.ic_we;
         e_wdata = (v.exp_owner == REQ_DC) ? v.dc_wdata : v.ic_wdata;
         wait_start(ok);
         for (int w = 0; w <= v.wait_cycles; w++) begin
            if (w > 0) @(negedge clk);
            check($sformatf("v%0d_busy%0d_start", i, w), 32'(mem_start), 32'h1);
            check($sformatf("v%0d_busy%0d_addr", i, w), mem_addr, e_addr);
            check($sformatf("v%0d_busy%0d_we", i, w), 32'(mem_we), 32'(e_we));
            check($sformatf("v%0d_busy%0d_wdata", i, w), mem_data_in, e_wdata);
            check($sformatf("v%0d_busy%0d_done", i, w), 32'(ic_done | dc_done), 32'h0);
         end
         mem_done = 1; mem_data_out = v.resp;
         @(negedge clk);
         mem_done = 0;
         if (v.exp_owner == REQ_DC) exp_dc_rd = v.exp_rdata;
         else                       exp_ic_rd = v.exp_rdata;
         check($sformatf("v%0d_ic_done", i), 32'(ic_done), 32'(v.exp_owner == REQ_IC));
         check($sformatf("v%0d_dc_done", i), 32'(dc_done), 32'(v.exp_owner == REQ_DC));
         check($sformatf("v%0d_err", i), 32'(err), 32'h0);
         check($sformatf("v%0d_start_low", i), 32'(mem_start), 32'h0);
         check($sformatf("v%0d_ic_rdata", i), ic_rdata, exp_ic_rd);
         check($sformatf("v%0d_dc_rdata", i), dc_rdata, exp_dc_rd);
      end
      ic_req = 0; dc_req = 0; ic_we = 0; dc_we = 0;

      // Stray mem_done while idle: no pulses, no data capture.
      @(negedge clk);
      mem_done = 1; mem_data_out = make_word(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("stray_done_pulse", 32'(ic_done | dc_done | err), 32'h0);
         check("stray_start", 32'(mem_start), 32'h0);
      end
      check("stray_ic_rdata", ic_rdata, wp);
      check("stray_dc_rdata", dc_rdata, we_);
      mem_done = 0;

      // Zero-wait memory: done two cycles after req.
      @(negedge clk);
      ic_req = 1; ic_addr = 32'h3000; ic_we = 0;
      @(negedge clk);
      check("zw_start", 32'(mem_start), 32'h1);
      check("zw_early_done", 32'(ic_done), 32'h0);
      mem_done = 1; mem_data_out = wf;
      @(negedge clk);
      mem_done = 0; ic_req = 0;
      check("zw_ic_done", 32'(ic_done), 32'h1);
      check("zw_ic_rdata", ic_rdata, wf);
      check("zw_start_low", 32'(mem_start), 32'h0);

      // Watchdog: ic read never completes while dc queues behind it.
      @(negedge clk);
      ic_req = 1; ic_addr = 32'h4000; ic_we = 0;
      mem_data_out = make_word(8'h77, 8'h77, 8'h77, 8'h77);
      @(negedge clk);
      dc_req = 1; dc_addr = 32'h5000; dc_we = 0;
      busy = 0;
      for (int k = 0; k < 20 && mem_start; k++) begin
         busy++;
         @(negedge clk);
      end
      check("to_busy_cycles", 32'(busy), 32'd8);
      check("to_ic_done", 32'(ic_done), 32'h1);
      check("to_err", 32'(err), 32'h1);
      check("to_ic_rdata", ic_rdata, 32'h0);
      check("to_dc_done", 32'(dc_done), 32'h0);
      ic_req = 0;
      wait_start(ok);
      check("to_next_addr", mem_addr, 32'h5000);
      mem_done = 1; mem_data_out = wg;
      @(negedge clk);
      mem_done = 0; dc_req = 0;
      check("to_next_dc_done", 32'(dc_done), 32'h1);
      check("to_next_err", 32'(err), 32'h0);
      check("to_next_dc_rdata", dc_rdata, wg);

      // Reset while a dc read is in flight.
      dc_req = 1; dc_addr = 32'h6000; dc_we = 0;
      wait_start(ok);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_start", 32'(mem_start), 32'h0);
      check("mid_rst_dc_done", 32'(dc_done), 32'h0);
      check("mid_rst_err", 32'(err), 32'h0);
      check("mid_rst_dc_rdata", dc_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      wait_start(ok);
      check("post_rst_addr", mem_addr, 32'h6000);
      mem_done = 1; mem_data_out = wh;
      @(negedge clk);
      mem_done = 0; dc_req = 0;
      check("post_rst_dc_done", 32'(dc_done), 32'h1);
      check("post_rst_dc_rdata", dc_rdata, wh);
      check("post_rst_ic_done", 32'(ic_done), 32'h0);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
